serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial multi-bit adder.
- Latches two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock, LSB first, through a single one-bit full-adder cell.
- A registered carry links successive bits.
- Shifts sum bits into a result register and signals completion with a one-cycle done pulse. Sits between operand sources (switches/registers) and result display/consumer logic.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an addition; sampled only when busy=0
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- c_in  input  1  carry-in; captured on the accepting edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum/c_out valid
- sum  output  WIDTH  result, held until next accepted start
- c_out  output  1  final carry, held with sum

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge, any state):
  - State goes to IDLE; busy=0, done=0, sum=0, c_out=0.
  - Internal shift registers, bit counter and carry register are cleared.
  - rst has priority over start.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - start is accepted at edge E0 when state is IDLE or DONE.
  - On acceptance: a, b and c_in load into operand shift registers and the carry register; the counter clears; state goes to RUN; busy=1 from the cycle after E0.
  - sum/c_out keep their previous values until overwritten.
- RUN, edges E1..E_WIDTH:
  - The full-adder cell combines the operand LSBs and the carry register.
  - The s bit shifts into the sum register MSB end; sum register shifts right.
  - Operand registers shift right; the carry register takes the cell's c_out.
  - The counter increments.
  - At edge E_WIDTH (counter = WIDTH-1): state goes to DONE, busy=0, done=1, and c_out is driven from the final carry.
  - After E_WIDTH, sum holds the full WIDTH-bit result in natural bit order.
- DONE:
  - Lasts exactly one cycle with done=1.
  - Next edge: IDLE if start=0. If start=1, a new operation is accepted (back-to-back) and done drops.
- Latency and throughput:
  - start sampled at E0 -> done high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after acceptance.
  - Throughput: one addition per WIDTH+1 cycles.
- start while busy=1 is ignored; operands are not re-captured and the in-flight result is unaffected.
- a, b and c_in may change freely after the accepting edge.
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); no overflow flag.
- done never asserts without a preceding accepted start. It never asserts in consecutive cycles.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH constant
- Counter width: $clog2(WIDTH), local.
- One natural sub-module: the team's existing one-bit full-adder cell One_Bit (inputs a, b, c_in; outputs c_out, s), instantiated once as the combinational datapath.
- Controller, shift registers and carry flop live in serial_adder.

Test Plan (WIDTH=8):
- Basic add: rst, then start with a=0x3C, b=0x42, c_in=0 -> done after 9 edges; sum=0x7E, c_out=0; busy high for exactly 8 cycles.
- Carry ripple: a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
- Start while busy: start a=0x10, b=0x20. On cycle 3 pulse start with a=0xAA, b=0x55 -> single done, sum=0x30, c_out=0; no second done.
- Reset mid-operation: start a=0x81, b=0x81. Assert rst on cycle 4 -> next cycle busy=0, done=0, sum=0x00, c_out=0. No done appears afterwards without a new start.
- Back-to-back: hold start=1 during the DONE cycle with a=0x01, b=0x02, c_in=1 -> first result stays held. Second done 9 edges later with sum=0x04, c_out=0.
- Randomised sweep: 500 random a, b, c_in -> {c_out,sum} equals a+b+c_in every time; done width always 1 cycle.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: controller state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_adder_one_bit.sv
// One-bit full-adder cell used as the whole datapath of the serial adder.
module One_Bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic c_out,
    output logic s
);

    // Sum is the parity of the three inputs; carry is generate or propagate.
    always_comb begin
        s     = a ^ b ^ c_in;
        c_out = (a & b) | (c_in & (a ^ b));
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches a, b and c_in on an accepted start,
// then pushes one bit pair per clock (LSB first) through a single full-adder
// cell. The result and final carry are presented with a one-cycle done pulse
// and held until the next operation completes.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             c_out_r;
    logic [CNT_W-1:0] cnt;
    logic             cell_s;
    logic             cell_c;

    One_Bit u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .c_in  (carry),
        .c_out (cell_c),
        .s     (cell_s)
    );

    // Status flags decode straight from the controller state, so done is
    // exactly as wide as the DONE state.
    always_comb begin
        busy  = (state == RUN);
        done  = (state == DONE);
        sum   = sum_r;
        c_out = c_out_r;
    end

    // Controller, operand shifters, carry flop and result registers. The sum
    // bits collect in a private shifter so the visible result only changes
    // when a whole new answer is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            sum_r   <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {cell_s, sum_sh[WIDTH-1:1]};
                    carry  <= cell_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum_r   <= {cell_s, sum_sh[WIDTH-1:1]};
                        c_out_r <= cell_c;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes hand-computed results
// into a queue, a monitor pops and compares whenever done is seen.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    logic [WIDTH:0]   expQ[$];
    int               checkCount = 0;
    int               errorCount = 0;
    int               doneCount  = 0;
    logic             prevDone   = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue a one-cycle start pulse; optionally record the expected result.
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vc, input logic [WIDTH:0] expected,
                                 input bit push);
        start = 1'b1;
        a     = va;
        b     = vb;
        c_in  = vc;
        if (push) expQ.push_back(expected);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        c_in  = 1'($urandom);
    endtask

    // Wait (bounded) until done is visible; report busy cycles and latency.
    task automatic waitDone(output int busyCycles, output int waitCycles);
        bit seen = 0;
        busyCycles = 0;
        waitCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busyCycles++;
            waitCycles++;
            @(negedge clk);
        end
        if (!seen) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
        end
    endtask

    // Monitor: every done pops one expected result and must not repeat.
    always @(negedge clk) begin
        if (!rst && done) begin
            doneCount++;
            checkOutput("done_width", 32'(prevDone), 32'd0);
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_done: got done with empty scoreboard, expected no done");
            end else begin
                logic [WIDTH:0] e;
                e = expQ.pop_front();
                checkOutput("sum", 32'(sum), 32'(e[WIDTH-1:0]));
                checkOutput("c_out", 32'(c_out), 32'(e[WIDTH]));
            end
        end
        prevDone = done;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyCycles;
        int waitCycles;
        int doneBefore;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_c_out", 32'(c_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add with busy width and latency.
        $display("[TB] basic add");
        applyStimulus(8'h3C, 8'h42, 1'b0, 9'h07E, 1);
        waitDone(busyCycles, waitCycles);
        checkOutput("busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("latency", 32'(waitCycles + 1), 32'(WIDTH + 1));
        @(negedge clk);
        checkOutput("done_drops", 32'(done), 32'd0);
        checkOutput("sum_held", 32'(sum), 32'h7E);

        // Carry ripple.
        $display("[TB] carry ripple");
        applyStimulus(8'hFF, 8'h01, 1'b0, 9'h100, 1);
        waitDone(busyCycles, waitCycles);
        @(negedge clk);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1);
        waitDone(busyCycles, waitCycles);
        @(negedge clk);

        // Start while busy is ignored.
        $display("[TB] start while busy");
        doneBefore = doneCount;
        applyStimulus(8'h10, 8'h20, 1'b0, 9'h030, 1);
        @(negedge clk);
        applyStimulus(8'hAA, 8'h55, 1'b0, 9'h000, 0);
        waitDone(busyCycles, waitCycles);
        repeat (15) @(negedge clk);
        checkOutput("single_done", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("idle_sum", 32'(sum), 32'h30);

        // Reset mid-operation.
        $display("[TB] reset mid-operation");
        doneBefore = doneCount;
        applyStimulus(8'h81, 8'h81, 1'b0, 9'h102, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expQ.delete();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_c_out", 32'(c_out), 32'd0);
        repeat (15) @(negedge clk);
        checkOutput("no_done_after_rst", 32'(doneCount - doneBefore), 32'd0);

        // Back-to-back: restart during the DONE cycle.
        $display("[TB] back-to-back");
        applyStimulus(8'h3C, 8'h42, 1'b1, 9'h07F, 1);
        waitDone(busyCycles, waitCycles);
        applyStimulus(8'h01, 8'h02, 1'b1, 9'h004, 1);
        checkOutput("b2b_done_drop", 32'(done), 32'd0);
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_sum_held", 32'(sum), 32'h7F);
        waitDone(busyCycles, waitCycles);
        checkOutput("b2b_latency", 32'(waitCycles + 1), 32'(WIDTH + 1));
        @(negedge clk);

        // Randomised sweep against integer addition.
        $display("[TB] random sweep");
        for (int i = 0; i < 500; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            applyStimulus(ra, rb, rc, (WIDTH+1)'(ra) + (WIDTH+1)'(rb) + (WIDTH+1)'(rc), 1);
            waitDone(busyCycles, waitCycles);
            if ((i % 2) == 0) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
